// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with req/ack memory port and hold buffer.
// Define IF_PERF_CNT_EN to build the fetch/wait performance counters.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        stallreq_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] wait_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_addr;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        req;
    logic        deliver;
    logic        latch_req;
    logic        st_bubble;
    logic        st_hold;
    logic        st_run;
    logic        unused_stall;

    assign unused_stall = ^{stall[5:3], stall[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (latch_req) begin
                req_addr <= pc_i;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req        = 1'b0;
        mem_addr_o = req_addr;
        deliver    = 1'b0;
        latch_req  = 1'b0;
        unique case (state)
            IDLE: begin
                req        = ce_i & ~flush & ~hold_valid;
                mem_addr_o = pc_i;
                if (req) begin
                    if (mem_ack_i) begin
                        deliver = 1'b1;
                    end else begin
                        latch_req = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                req = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                    deliver   = ~flush;
                end else if (flush | ~ce_i) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                req = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory sees no request at all while reset is held.
    assign mem_req_o  = req & rst;
    assign stallreq_o = (mem_req_o & ~mem_ack_i) | (state == DROP);

    assign st_bubble = ~flush & stall[1] & ~stall[2];
    assign st_hold   = ~flush & stall[1] & stall[2];
    assign st_run    = ~flush & ~stall[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_o    <= 32'h0;
            id_inst_o  <= 32'h0;
            hold_valid <= 1'b0;
            hold_pc    <= 32'h0;
            hold_inst  <= 32'h0;
        end else begin
            unique case (1'b1)
                flush: begin
                    id_pc_o    <= 32'h0;
                    id_inst_o  <= 32'h0;
                    hold_valid <= 1'b0;
                end
                st_bubble: begin
                    id_pc_o   <= 32'h0;
                    id_inst_o <= 32'h0;
                    if (deliver) begin
                        hold_valid <= 1'b1;
                        hold_pc    <= mem_addr_o;
                        hold_inst  <= mem_data_i;
                    end
                end
                st_hold: begin
                    if (deliver) begin
                        hold_valid <= 1'b1;
                        hold_pc    <= mem_addr_o;
                        hold_inst  <= mem_data_i;
                    end
                end
                st_run: begin
                    if (hold_valid) begin
                        id_pc_o    <= hold_pc;
                        id_inst_o  <= hold_inst;
                        hold_valid <= 1'b0;
                    end else if (deliver) begin
                        id_pc_o   <= mem_addr_o;
                        id_inst_o <= mem_data_i;
                    end else begin
                        id_pc_o   <= 32'h0;
                        id_inst_o <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'h0;
            wait_cnt  <= 32'h0;
        end else begin
            if (deliver) begin
                fetch_cnt <= fetch_cnt + 32'h1;
            end
            if (stallreq_o) begin
                wait_cnt <= wait_cnt + 32'h1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign wait_cnt_o  = wait_cnt;
`else
    assign fetch_cnt_o = 32'h0;
    assign wait_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch with a variable-latency memory.
// Expected counter values follow IF_PERF_CNT_EN.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic [5:0]  stall = 6'h0;
    logic        flush = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        stallreq_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] wait_cnt_o;

    int checks = 0;
    int errors = 0;
    int wait_n = 0;
    int wcnt;
    logic [63:0] exp_q[$];
    logic [63:0] prev = 64'h0;

`ifdef IF_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd5;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .stall      (stall),
        .flush      (flush),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .stallreq_o (stallreq_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .fetch_cnt_o(fetch_cnt_o),
        .wait_cnt_o (wait_cnt_o)
    );

    always #5 clk = ~clk;

    // Memory: acks after wait_n wait cycles; word = 0x24020000 | addr/4.
    assign mem_ack_i  = mem_req_o && (wcnt == wait_n);
    assign mem_data_i = mem_ack_i ? (32'h24020000 | (mem_addr_o >> 2)) : 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (mem_req_o && !mem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new non-bubble ID value must match the queue head.
    always @(negedge clk) begin
        if (rst && {id_pc_o, id_inst_o} != 64'h0 &&
            {id_pc_o, id_inst_o} != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h/%h expected none",
                         id_pc_o, id_inst_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({id_pc_o, id_inst_o} !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %h/%h expected %h/%h",
                             id_pc_o, id_inst_o, e[63:32], e[31:0]);
                end
            end
        end
        prev = {id_pc_o, id_inst_o};
    end

    task automatic fetch(input logic [31:0] a, input int nw,
                         input logic [31:0] inst, output int stc,
                         output int cyc, output int bad);
        logic acked;
        acked = 1'b0;
        pc_i = a;
        ce_i = 1'b1;
        wait_n = nw;
        stc = 0;
        cyc = 0;
        bad = 0;
        exp_q.push_back({a, inst});
        for (int k = 0; k < 20 && !acked; k++) begin
            @(negedge clk);
            cyc++;
            if (mem_addr_o != a || !mem_req_o) bad++;
            if (stallreq_o) stc++;
            acked = mem_ack_i;
        end
        if (!acked) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: got no ack expected ack at %h", a);
        end
        @(posedge clk);
        #1;
    endtask

    int stc, cyc, bad;
    logic acked;

    initial begin
        ce_i = 1'b1;
        #2;
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_id_pc", id_pc_o, 32'h0);
        chk("rst_id_inst", id_inst_o, 32'h0);
        chk("rst_fcnt", fetch_cnt_o, 32'h0);
        chk("rst_wcnt", wait_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        fetch(32'h0, 0, 32'h24020000, stc, cyc, bad);
        chk("zw0_pc", id_pc_o, 32'h0);
        chk("zw0_stall", stc, 0);
        chk("zw0_cyc", cyc, 1);
        fetch(32'h4, 0, 32'h24020001, stc, cyc, bad);
        chk("zw4_pc", id_pc_o, 32'h4);
        chk("zw4_stall", stc, 0);
        fetch(32'h8, 0, 32'h24020002, stc, cyc, bad);
        chk("zw8_inst", id_inst_o, 32'h24020002);
        chk("zw8_stall", stc, 0);

        fetch(32'h10, 2, 32'h24020004, stc, cyc, bad);
        ce_i = 1'b0;
        chk("w2_stall", stc, 2);
        chk("w2_cyc", cyc, 3);
        chk("w2_addr", bad, 0);
        chk("w2_pc", id_pc_o, 32'h10);

        pc_i = 32'h20;
        ce_i = 1'b1;
        wait_n = 3;
        @(negedge clk);
        chk("fl_idle_stall", {31'h0, stallreq_o}, 32'h1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy_stall", {31'h0, stallreq_o}, 32'h1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        ce_i = 1'b0;
        bad = 0;
        acked = 1'b0;
        for (int k = 0; k < 10 && !acked; k++) begin
            @(negedge clk);
            if (!stallreq_o || mem_addr_o != 32'h20 || !mem_req_o) bad++;
            acked = mem_ack_i;
        end
        chk("fl_drop_ack", {31'h0, acked}, 32'h1);
        chk("fl_drop_hold", bad, 0);
        @(posedge clk);
        #1;
        chk("fl_inst", id_inst_o, 32'h0);
        chk("fl_idle_req", {31'h0, mem_req_o}, 32'h0);
        chk("fl_idle_stallreq", {31'h0, stallreq_o}, 32'h0);

        fetch(32'hC, 0, 32'h24020003, stc, cyc, bad);
        pc_i = 32'h14;
        stall = 6'b000110;
        @(negedge clk);
        chk("hd_ack", {31'h0, mem_ack_i}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hd_valid", {31'h0, dut.hold_valid}, 32'h1);
        chk("hd_noreq", {31'h0, mem_req_o}, 32'h0);
        chk("hd_pc_held", id_pc_o, 32'hC);
        chk("hd_inst_held", id_inst_o, 32'h24020003);
        exp_q.push_back({32'h14, 32'h24020005});
        @(posedge clk);
        #1;
        stall = 6'h0;
        ce_i = 1'b0;
        @(negedge clk);
        chk("hd_pc_pre", id_pc_o, 32'hC);
        @(posedge clk);
        #1;
        chk("hd_inst_out", id_inst_o, 32'h24020005);
        chk("hd_cleared", {31'h0, dut.hold_valid}, 32'h0);

        fetch(32'h2C, 0, 32'h2402000B, stc, cyc, bad);
        stall = 6'b000110;
        pc_i = 32'h30;
        wait_n = 3;
        @(posedge clk);
        #2;
        chk("ar_pre_req", {31'h0, mem_req_o}, 32'h1);
        chk("ar_pre_pc", id_pc_o, 32'h2C);
        rst = 1'b0;
        #1;
        chk("ar_req", {31'h0, mem_req_o}, 32'h0);
        chk("ar_id_pc", id_pc_o, 32'h0);
        chk("ar_id_inst", id_inst_o, 32'h0);
        chk("ar_fcnt", fetch_cnt_o, 32'h0);
        chk("ar_wcnt", wait_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 6'h0;

        fetch(32'h40, 1, 32'h24020010, stc, cyc, bad);
        chk("pc_restart", id_pc_o, 32'h40);
        chk("pc_w1_stall", stc, 1);
        fetch(32'h44, 1, 32'h24020011, stc, cyc, bad);
        fetch(32'h48, 1, 32'h24020012, stc, cyc, bad);
        fetch(32'h4C, 1, 32'h24020013, stc, cyc, bad);
        fetch(32'h50, 1, 32'h24020014, stc, cyc, bad);
        ce_i = 1'b0;
        chk("pc_w1_addr", bad, 0);
        chk("perf_fetch", fetch_cnt_o, EXP_CNT);
        chk("perf_wait", wait_cnt_o, EXP_CNT);
        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage between the PC register and the decode stage. Takes the current `pc`/`ce`, runs a req/ack transaction against instruction memory (any latency, ≥0 wait cycles), and delivers `{pc, inst}` to ID through a pipeline register. Memory latency is absorbed by raising a stall request to the pipeline controller. A one-entry hold buffer keeps a returned word that decode cannot yet accept, and in-flight fetches are dropped on flush.

## Interface
- No parameters; widths come from `RegBus`/`InstAddrBus` (32 bits).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_i` in 32: fetch address from the PC register.
- `ce_i` in 1: fetch enable from the PC register.
- `stall` in 6: controller stall vector; this block uses bits [1] and [2].
- `flush` in 1: exception/interrupt flush.
- `mem_req_o` out 1: instruction memory request.
- `mem_addr_o` out 32: request address.
- `mem_ack_i` in 1: data valid and request complete, same cycle.
- `mem_data_i` in 32: instruction word.
- `stallreq_o` out 1: fetch-not-ready request to the controller (combinational).
- `id_pc_o` out 32: registered PC to decode.
- `id_inst_o` out 32: registered instruction to decode; 0 means NOP.
- `fetch_cnt_o` out 32: completed-fetch counter (see Configuration).
- `wait_cnt_o` out 32: memory wait-cycle counter (see Configuration).

## Operation
- States: IDLE, BUSY, DROP.
  - Internal registers: `req_addr`, `hold_valid`, `hold_pc`, `hold_inst`.
- IDLE:
  - `mem_req_o = ce_i & ~flush & ~hold_valid`; `mem_addr_o = pc_i`.
  - If requested with `mem_ack_i=0`: latch `req_addr <= pc_i` and go to BUSY.
  - If acked in the same cycle: remain in IDLE.
- BUSY:
  - `mem_req_o=1`; `mem_addr_o=req_addr`.
  - On ack: go to IDLE.
  - On `flush` without ack: go to DROP.
  - `ce_i` dropping while BUSY also goes to DROP.
- DROP:
  - `mem_req_o=1`; `mem_addr_o=req_addr`.
  - On ack: discard the data and go to IDLE.
  - No accepted request is ever withdrawn; the address stays stable until ack.
- A delivered word is `{mem_addr_o, mem_data_i}` on an ack in IDLE or BUSY with `flush=0`.
- `stallreq_o = (mem_req_o & ~mem_ack_i) | (state==DROP)`.
- ID register update, evaluated in this priority order:
  1. `flush`: `id_pc_o`, `id_inst_o` <= 0; `hold_valid` <= 0.
  2. `stall[1]=1`, `stall[2]=0`: load bubble (0, 0).
     - A word delivered this cycle goes to the hold buffer (`hold_valid <= 1`).
  3. `stall[1]=1`, `stall[2]=1`: hold the outputs.
     - A delivered word goes to the hold buffer.
  4. `stall[1]=0`: load the hold buffer if valid (and clear it); else load the delivered word; else load a bubble.
- While `hold_valid=1`, no new request is issued; the PC is frozen by the controller.
- Branches need no handling here: the word fetched after a branch is the delay slot and is kept.

## Timing
- Zero-wait memory (ack in the request cycle): `id_*` are valid on the next rising edge, so one fetch per cycle.
- N-wait memory: `stallreq_o` is high for N cycles; `id_*` load at the edge after the ack.
- Reset (`rst=0`, asynchronous), effective immediately:
  - state IDLE; `hold_valid=0`; `req_addr=0`.
  - `id_pc_o`, `id_inst_o`, and both counters are 0.
  - `mem_req_o` is forced to 0 while `rst=0`.
- Reset mid-BUSY abandons the transaction; memory is reset from the same `rst`.
- Flush and ack in the same cycle: the data is dropped and the state goes to IDLE; no DROP cycle.
- Flush while `hold_valid=1`: the hold buffer is cleared.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `fetch_cnt_o` increments on every delivered word.
  - `wait_cnt_o` increments every cycle with `stallreq_o=1`.
  - Both are 32 bits, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- `IF_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are synthesized.

## Test plan
- Reset release, `ce_i=1`, zero-wait memory, pc 0, 4, 8 -> `id_pc_o` = 0, 4, 8 on consecutive cycles; `id_inst_o` = memory words; `stallreq_o=0` throughout.
- 2-wait memory at pc 0x10 -> `stallreq_o` high for 2 cycles; `mem_addr_o=0x10` stable for 3 cycles; `id_pc_o=0x10` the cycle after the ack.
- Flush in the first BUSY cycle of a 3-wait fetch -> state DROP; `stallreq_o` stays high until the ack; the dropped word never appears; `id_inst_o=0`.
- Ack with `stall[1]=1`, `stall[2]=1` (word 0x24020005) -> `hold_valid=1`, no new request, outputs held; after `stall` returns to 0, `id_inst_o=0x24020005` one cycle later.
- Assert `rst=0` asynchronously mid-BUSY -> `mem_req_o`, `id_*` and counters go to 0 without waiting for a clock edge; after release, fetching restarts from `pc_i`.
- With `IF_PERF_CNT_EN`: 5 fetches with 1 wait each -> `fetch_cnt_o=5`, `wait_cnt_o=5`; without it both stay 0.
